ps2_key_release: RTL and testbench

Receives the raw PS/2 keyboard serial stream, assembles 11-bit frames into bytes and tracks make/break/extended prefixes. It reports each completed key release as a scancode plus a one-cycle `ready` pulse. The block sits directly upstream of the game-playing stage: its `scancode`/`ready` outputs drive that stage's `scancode`/`ready` inputs. It also exposes key-held status for the menu and difficulty logic.

---
 rtl/ps2_key_release.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ps2_key_release.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_release.sv
// ps2_key_release
//   Receives the raw PS/2 keyboard stream, assembles 11-bit frames into bytes
//   and tracks make / break (F0) / extended (E0) prefixes. Each completed key
//   release is reported as a scancode with a one-cycle ready pulse. Key-held
//   status (key_down / held_code) is exposed for menu and difficulty logic.
//
//   Optional feature macro: PS2_PARITY_CHECK_EN
//     defined   - bit 9 must be odd parity over the data; bad frames are dropped
//     undefined - bit 9 is sampled and ignored
//
// Parameters:
//   TIMEOUT_CYCLES - idle clk cycles mid-frame before the frame is abandoned
//   SYNC_STAGES    - synchronizer depth on ps2_clk / ps2_data (2..3)
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   ps2_clk   in   asynchronous PS/2 clock from the connector
//   ps2_data  in   asynchronous PS/2 data from the connector
//   scancode  out  code of the most recently released key
//   ready     out  one-cycle pulse, a release completed
//   extended  out  released key carried an E0 prefix
//   key_down  out  a make code was received with no matching break since
//   held_code out  last make code received
//   frame_err out  one-cycle pulse on a discarded frame
module ps2_key_release #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       ready,
  output logic       extended,
  output logic       key_down,
  output logic [7:0] held_code,
  output logic       frame_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]      CODE_EXT = 8'hE0;
  localparam logic [7:0]      CODE_BRK = 8'hF0;

  // Odd parity holds when the data plus the parity bit contain an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    BRK  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ps2_clk_sync_r;
  logic [SYNC_STAGES-1:0] ps2_data_sync_r;
  logic                   clk_hist_r;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall_s;

  // Synchronizer chains; idle-high so a reset never fakes a clock fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_sync_r  <= {SYNC_STAGES{1'b1}};
      ps2_data_sync_r <= {SYNC_STAGES{1'b1}};
      clk_hist_r      <= 1'b1;
    end else begin
      ps2_clk_sync_r  <= {ps2_clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      ps2_data_sync_r <= {ps2_data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_hist_r      <= ps2_clk_s;
    end
  end

  assign ps2_clk_s  = ps2_clk_sync_r[SYNC_STAGES-1];
  assign ps2_data_s = ps2_data_sync_r[SYNC_STAGES-1];
  assign fall_s     = clk_hist_r & ~ps2_clk_s;

  // ---------------------------------------------------------------------------
  // Frame receiver and watchdog
  // ---------------------------------------------------------------------------
  logic [3:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic [WD_W-1:0] wd_r;
  logic            byte_valid_r;
  logic            frame_err_r;
  logic            frame_ok_s;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_r;

  // Captures the parity bit so it can be checked against the data at stop time.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (fall_s && (bit_cnt_r == 4'd9)) begin
      parity_r <= ps2_data_s;
    end
  end

  assign frame_ok_s = ps2_data_s & odd_parity_ok(shift_r, parity_r);
`else
  assign frame_ok_s = ps2_data_s;
`endif

  // Bit counter, data shift register, watchdog and the per-frame result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      wd_r         <= '0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_s) begin
        // A fall always clears the watchdog, so a stop bit beats a timeout.
        wd_r <= '0;
        case (bit_cnt_r)
          4'd0: begin
            if (!ps2_data_s) begin
              bit_cnt_r <= 4'd1;
            end
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shift_r   <= {ps2_data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          4'd9: begin
            bit_cnt_r <= 4'd10;
          end
          4'd10: begin
            bit_cnt_r <= 4'd0;
            if (frame_ok_s) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          default: begin
            bit_cnt_r <= 4'd0;
          end
        endcase
      end else if (bit_cnt_r != 4'd0) begin
        if (wd_r == WD_LIMIT) begin
          bit_cnt_r   <= 4'd0;
          wd_r        <= '0;
          frame_err_r <= 1'b1;
        end else begin
          wd_r <= wd_r + 1'b1;
        end
      end else begin
        wd_r <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix FSM
  // ---------------------------------------------------------------------------
  state_t     state_r, state_s;
  logic       ext_r, ext_s;
  logic [7:0] scancode_r, scancode_s;
  logic       ready_r, ready_s;
  logic       extended_r, extended_s;
  logic       key_down_r, key_down_s;
  logic [7:0] held_code_r, held_code_s;

  // State and output registers for the prefix tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ext_r       <= 1'b0;
      scancode_r  <= 8'h00;
      ready_r     <= 1'b0;
      extended_r  <= 1'b0;
      key_down_r  <= 1'b0;
      held_code_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      ext_r       <= ext_s;
      scancode_r  <= scancode_s;
      ready_r     <= ready_s;
      extended_r  <= extended_s;
      key_down_r  <= key_down_s;
      held_code_r <= held_code_s;
    end
  end

  // Next-state and output decode, advanced only when a good byte arrives.
  always_comb begin
    state_s     = state_r;
    ext_s       = ext_r;
    scancode_s  = scancode_r;
    ready_s     = 1'b0;
    extended_s  = extended_r;
    key_down_s  = key_down_r;
    held_code_s = held_code_r;
    if (byte_valid_r) begin
      case (state_r)
        IDLE: begin
          if (shift_r == CODE_EXT) begin
            state_s = EXT;
          end else if (shift_r == CODE_BRK) begin
            state_s = BRK;
            ext_s   = 1'b0;
          end else begin
            held_code_s = shift_r;
            key_down_s  = 1'b1;
          end
        end
        EXT: begin
          if (shift_r == CODE_BRK) begin
            state_s = BRK;
            ext_s   = 1'b1;
          end else if (shift_r == CODE_EXT) begin
            state_s = EXT;
          end else begin
            held_code_s = shift_r;
            key_down_s  = 1'b1;
            state_s     = IDLE;
          end
        end
        BRK: begin
          if ((shift_r == CODE_EXT) || (shift_r == CODE_BRK)) begin
            state_s = BRK;
          end else begin
            scancode_s = shift_r;
            extended_s = ext_r;
            ready_s    = 1'b1;
            state_s    = IDLE;
            // Releasing some other key leaves the held key's status alone.
            if (shift_r == held_code_r) begin
              key_down_s = 1'b0;
            end else begin
              key_down_s = key_down_r;
            end
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign scancode  = scancode_r;
  assign ready     = ready_r;
  assign extended  = extended_r;
  assign key_down  = key_down_r;
  assign held_code = held_code_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_key_release.sv
// Self-checking bench for ps2_key_release: directed PS/2 frames with
// hand-computed expectations. Runs with a short timeout and a fast PS/2 clock.
module tb_ps2_key_release;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 10;
  localparam int GAP     = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scancode;
  logic       ready;
  logic       extended;
  logic       key_down;
  logic [7:0] held_code;
  logic       frame_err;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  int err_cnt = 0;
  int kd_low_cnt = 0;
  logic       kd_arm = 1'b0;
  logic [7:0] last_sc = 8'h00;
  logic       last_ext = 1'b0;
  logic       last_kd = 1'b1;
  int r0, e0;

  ps2_key_release #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scancode(scancode), .ready(ready), .extended(extended),
    .key_down(key_down), .held_code(held_code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (ready) begin
      ready_cnt <= ready_cnt + 1;
      ready_cyc <= cyc;
      last_sc   <= scancode;
      last_ext  <= extended;
      last_kd   <= key_down;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (kd_arm && !key_down) kd_low_cnt <= kd_low_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame (or its first nbits bits) then idles GAP cycles.
  task automatic send_frame(input logic [7:0] b, input logic flip_par,
                            input logic bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_scancode", {24'd0, scancode}, 32'h00);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_extended", {31'd0, extended}, 32'd0);
    check_eq("rst_key_down", {31'd0, key_down}, 32'd0);
    check_eq("rst_held_code", {24'd0, held_code}, 32'h00);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain make then release.
    send(8'h1C);
    check_eq("make_key_down", {31'd0, key_down}, 32'd1);
    check_eq("make_held", {24'd0, held_code}, 32'h1C);
    check_eq("make_no_ready", ready_cnt, 32'd0);
    send(8'hF0);
    send(8'h1C);
    check_eq("rel_ready_cnt", ready_cnt, 32'd1);
    check_eq("rel_scancode", {24'd0, last_sc}, 32'h1C);
    check_eq("rel_extended", {31'd0, last_ext}, 32'd0);
    check_eq("rel_kd_same_cycle", {31'd0, last_kd}, 32'd0);
    // Observed just after the 4th edge, i.e. the value present at the 5th edge.
    check_eq("rel_latency", ready_cyc - stop_cyc, 32'd4);

    // Extended make then extended release.
    send(8'hE0);
    send(8'h75);
    check_eq("ext_held", {24'd0, held_code}, 32'h75);
    check_eq("ext_key_down", {31'd0, key_down}, 32'd1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_eq("ext_ready_cnt", ready_cnt, 32'd2);
    check_eq("ext_scancode", {24'd0, last_sc}, 32'h75);
    check_eq("ext_extended", {31'd0, last_ext}, 32'd1);
    check_eq("ext_kd_released", {31'd0, key_down}, 32'd0);

    // Parity bit inverted.
    pulse_reset();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("par_err_once", err_cnt - e0, 32'd1);
    check_eq("par_key_down", {31'd0, key_down}, 32'd0);
    check_eq("par_held", {24'd0, held_code}, 32'h00);
`else
    check_eq("par_no_err", err_cnt - e0, 32'd0);
    check_eq("par_held", {24'd0, held_code}, 32'h1C);
`endif

    // Bad stop bit is always an error.
    pulse_reset();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_eq("stop_err_once", err_cnt - e0, 32'd1);
    check_eq("stop_held", {24'd0, held_code}, 32'h00);
    check_eq("stop_key_down", {31'd0, key_down}, 32'd0);

    // Partial frame abandoned by the watchdog, then a clean release.
    pulse_reset();
    e0 = err_cnt;
    r0 = ready_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    check_eq("tmo_err_once", err_cnt - e0, 32'd1);
    send(8'hF0);
    send(8'h29);
    check_eq("tmo_ready_cnt", ready_cnt - r0, 32'd1);
    check_eq("tmo_scancode", {24'd0, last_sc}, 32'h29);
    check_eq("tmo_no_more_err", err_cnt - e0, 32'd1);

    // Reset between break prefix and code returns the FSM to IDLE.
    pulse_reset();
    r0 = ready_cnt;
    send(8'hF0);
    pulse_reset();
    send(8'h1C);
    check_eq("rstmid_no_ready", ready_cnt - r0, 32'd0);
    check_eq("rstmid_held", {24'd0, held_code}, 32'h1C);
    check_eq("rstmid_key_down", {31'd0, key_down}, 32'd1);

    // Typematic repeats keep the key held and produce a single release.
    pulse_reset();
    r0 = ready_cnt;
    send(8'h1C);
    kd_arm = 1'b1;
    send(8'h1C);
    send(8'h1C);
    check_eq("typ_no_ready", ready_cnt - r0, 32'd0);
    send(8'hF0);
    kd_arm = 1'b0;
    @(negedge clk);
    check_eq("typ_kd_continuous", kd_low_cnt, 32'd0);
    send(8'h1C);
    check_eq("typ_ready_once", ready_cnt - r0, 32'd1);
    check_eq("typ_scancode", {24'd0, last_sc}, 32'h1C);
    check_eq("typ_kd_released", {31'd0, key_down}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
